// File: rtl/uart_cmd_parser.sv
// ASCII register-access command parser: "W a h l CR" writes, "R a CR" reads,
// replies "K", two hex chars or "E" followed by CR LF over a ready/valid link.
module uart_cmd_parser #(
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] regs_flat
);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA_HI,
        S_DATA_LO,
        S_EXPECT_CR,
        S_DISCARD,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_ERR,
        RSP_ACK,
        RSP_RD
    } resp_t;

    function automatic logic f_is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // Letters have bit 6 set; adding 9 maps 'A'/'a' low nibble 1 onto 10.
    function automatic logic [3:0] f_hex_val(input logic [7:0] b);
        logic [7:0] t;
        t = b + (b[6] ? 8'd9 : 8'd0);
        return t[3:0];
    endfunction

    function automatic logic [7:0] f_to_hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    resp_t       w_resp_sel;
    logic        w_commit;

    logic        r_op_wr;
    logic [3:0]  r_addr;
    logic [3:0]  r_hi;
    logic [3:0]  r_lo;
    logic [7:0]  r_resp [0:3];
    logic [2:0]  r_cnt;
    logic [7:0]  r_regs [0:15];

    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_is_hex;
    logic [3:0]  w_nib;
    logic        w_is_cr;
    logic        w_is_lf;
    logic        w_is_rd;
    logic        w_is_wr;
    logic [7:0]  w_rd_data;

    assign in_ready   = (r_state != S_RESP);
    assign out_valid  = (r_state == S_RESP);
    assign out_data   = r_resp[0];

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_is_hex   = f_is_hex(in_data);
    assign w_nib      = f_hex_val(in_data);
    assign w_is_cr    = (in_data == CH_CR);
    assign w_is_lf    = (in_data == CH_LF);
    assign w_is_rd    = (in_data == 8'h52) || (in_data == 8'h72);
    assign w_is_wr    = (in_data == 8'h57) || (in_data == 8'h77);
    assign w_rd_data  = r_regs[r_addr];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = r_regs[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_resp_sel  = RSP_NONE;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (w_is_rd || w_is_wr) begin
                        w_state_nxt = S_ADDR;
                    end else if (!(w_is_cr || w_is_lf)) begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_ADDR: begin
                if (w_in_fire) begin
                    if (w_is_hex) begin
                        w_state_nxt = r_op_wr ? S_DATA_HI : S_EXPECT_CR;
                    end else if (w_is_cr) begin
                        w_state_nxt = S_RESP;
                        w_resp_sel  = RSP_ERR;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_DATA_HI, S_DATA_LO: begin
                if (w_in_fire) begin
                    if (w_is_hex) begin
                        w_state_nxt = (r_state == S_DATA_HI) ? S_DATA_LO : S_EXPECT_CR;
                    end else if (w_is_cr) begin
                        w_state_nxt = S_RESP;
                        w_resp_sel  = RSP_ERR;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_EXPECT_CR: begin
                if (w_in_fire) begin
                    if (w_is_cr) begin
                        w_state_nxt = S_RESP;
                        w_resp_sel  = r_op_wr ? RSP_ACK : RSP_RD;
                        w_commit    = r_op_wr;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (w_in_fire && w_is_cr) begin
                    w_state_nxt = S_RESP;
                    w_resp_sel  = RSP_ERR;
                end
            end
            S_RESP: begin
                if (w_out_fire && (r_cnt == 3'd1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_wr <= 1'b0;
            r_addr  <= 4'h0;
            r_hi    <= 4'h0;
            r_lo    <= 4'h0;
            r_cnt   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_resp[i] <= 8'h00;
            end
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= REG_RESET;
            end
        end else begin
            if (w_in_fire) begin
                if ((r_state == S_IDLE) && (w_is_rd || w_is_wr)) r_op_wr <= w_is_wr;
                if ((r_state == S_ADDR) && w_is_hex)             r_addr  <= w_nib;
                if ((r_state == S_DATA_HI) && w_is_hex)          r_hi    <= w_nib;
                if ((r_state == S_DATA_LO) && w_is_hex)          r_lo    <= w_nib;
            end
            if (w_commit) begin
                r_regs[r_addr] <= {r_hi, r_lo};
            end
            // The buffer shifts toward slot 0 so out_data is always a plain register.
            case (w_resp_sel)
                RSP_ERR: begin
                    r_resp[0] <= CH_E;
                    r_resp[1] <= CH_CR;
                    r_resp[2] <= CH_LF;
                    r_resp[3] <= 8'h00;
                    r_cnt     <= 3'd3;
                end
                RSP_ACK: begin
                    r_resp[0] <= CH_K;
                    r_resp[1] <= CH_CR;
                    r_resp[2] <= CH_LF;
                    r_resp[3] <= 8'h00;
                    r_cnt     <= 3'd3;
                end
                RSP_RD: begin
                    r_resp[0] <= f_to_hex(w_rd_data[7:4]);
                    r_resp[1] <= f_to_hex(w_rd_data[3:0]);
                    r_resp[2] <= CH_CR;
                    r_resp[3] <= CH_LF;
                    r_cnt     <= 3'd4;
                end
                default: begin
                    if (w_out_fire) begin
                        r_resp[0] <= r_resp[1];
                        r_resp[1] <= r_resp[2];
                        r_resp[2] <= r_resp[3];
                        r_resp[3] <= 8'h00;
                        r_cnt     <= r_cnt - 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

ASCII register-access command parser sitting between the UART receive FIFO dequeue side and the UART transmitter. It consumes received bytes over a ready/valid interface and interprets single-line read/write commands against an internal bank of 16 eight-bit registers. It emits ASCII responses over a second ready/valid interface toward the transmit path. The register bank is exported flat for LEDs and other board-level controls.

## Interface
- REG_RESET, 8'h00, value loaded into every register on reset
- clk  input  1  system clock (125 MHz on board); all logic rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  8  received byte (from RX FIFO deq_data)
- in_valid  input  1  in_data valid
- in_ready  output  1  parser accepts in_data this cycle
- out_data  output  8  response byte (to TX data_in)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- regs_flat  output  128  register bank; reg[i] = regs_flat[8*i+7:8*i]

## Operation
- Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- Hex digits: '0'-'9', 'A'-'F', 'a'-'f'. Command letters 'R'/'r', 'W'/'w'. CR = 8'h0D, LF = 8'h0A.
- Command grammar:
  - Write: W a h l CR, where a is the register index (one hex digit), h is the data high nibble, and l is the data low nibble.
  - Read: R a CR.
- Responses:
  - Write: "K" CR LF (3 bytes).
  - Read: uppercase hex hi, hex lo, CR, LF (4 bytes).
  - Error: "E" CR LF (3 bytes).
- FSM states: IDLE, ADDR, DATA_HI, DATA_LO, EXPECT_CR, DISCARD, RESP.
- IDLE transitions:
  - 'R'/'W' latches the op and goes to ADDR.
  - CR or LF is ignored; stay in IDLE with no response.
  - Any other byte goes to DISCARD.
- ADDR transitions:
  - Hex digit latches the address, then goes to EXPECT_CR (read) or DATA_HI (write).
  - CR loads the error response and goes to RESP.
  - Any other byte goes to DISCARD.
- DATA_HI and DATA_LO transitions:
  - Hex digit latches the nibble and advances to the next state (DATA_LO, then EXPECT_CR).
  - CR gives an error response.
  - Any other byte goes to DISCARD.
- EXPECT_CR transitions:
  - CR executes the command: a write commits reg[a] and loads the K response; a read loads reg[a] as two hex chars. Then go to RESP.
  - Any other byte goes to DISCARD.
- DISCARD: consumes bytes until CR, then loads the error response and goes to RESP.
- RESP: a 4-byte response buffer with a length count of 3 or 4. Bytes are emitted in order, one per output fire. After the last fire, return to IDLE.
- in_ready = 1 in every state except RESP. No input is consumed while a response is pending.
- Read data is sampled at CR acceptance. A read of a register written by the immediately preceding command returns the new value.

## Timing
- Reset values (while rst_n low and immediately after release):
  - state = IDLE, in_ready = 1
  - out_valid = 0, out_data = 8'h00
  - all regs = REG_RESET, response buffer cleared
- Parsing consumes at most one byte per cycle. Back-to-back input fires are allowed in all parsing states.
- Terminating CR accepted in cycle N:
  - State is RESP in N+1.
  - out_valid = 1 and out_data = first response byte, both registered, in N+1.
  - For a write, regs_flat shows the new value in N+1.
- out_data and out_valid are held stable while out_valid & !out_ready.
- A response byte advances on each output fire. With out_ready held at 1, a 3-byte response occupies cycles N+1..N+3, and a 4-byte response occupies N+1..N+4.
- After the last output fire in cycle M, out_valid = 0 and in_ready = 1 in M+1.
- There is no combinational path from in_valid to out_valid, or from out_ready to in_ready. in_ready is decoded from the registered state only.
- Asserting rst_n low at any time, including mid-command or mid-response, immediately aborts all activity and restores the reset values. A partially sent response is dropped, not resumed.

## Test plan
- Send "W3A5" CR with out_ready = 1. Required: out_data sequence 'K', 8'h0D, 8'h0A; reg[3] = 8'hA5 one cycle after CR accept; all other regs = REG_RESET.
- After the write, send "r3" CR. Required: out_data sequence 'A', '5', 8'h0D, 8'h0A. Then send "WFff" CR followed by "RF" CR. Required: reg[15] = 8'hFF, and the read returns 'F', 'F', CR, LF.
- Send "Rz" CR, "W1F" CR (one digit short), and "X12" CR. Required: each produces exactly 'E', CR, LF, and no register changes.
- Send a bare CR, LF, then CR, LF. Required: no output fire and in_ready stays 1. A following "R0" CR returns '0', '0', CR, LF with REG_RESET = 0.
- Issue "R3" CR while holding out_ready = 0 for 10 cycles. Required: out_valid = 1 with out_data = 'A' stable throughout and in_ready = 0. Offered input bytes are not consumed, and the sequence completes correctly once out_ready rises.
- Drop rst_n low mid-response, after 2 bytes have fired. Required: out_valid = 0 and in_ready = 1 immediately; regs return to REG_RESET; the next command parses from IDLE normally.
